// File: rtl/fifo_mem_pkg.sv
// Shared constants for the FloPoCo word FIFO: exception field width,
// exception encodings and default geometry.
package fifo_mem_pkg;

  // FloPoCo exception field sits above the IEEE-style payload.
  localparam int EXC_W = 2;

  typedef enum logic [EXC_W-1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 2;

endpackage

// File: rtl/fifo_mem_ctrl.sv
// FIFO bookkeeping: read/write pointers, occupancy count, full/empty
// flags and the accept decisions for each port.
module fifo_ctrl
  import fifo_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic                 do_wr,
  output logic                 do_rd,
  output logic [ADDR_BITS-1:0] wr_ptr,
  output logic [ADDR_BITS-1:0] rd_ptr,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_FULL = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A read never bypasses an empty FIFO; a write into a full FIFO is allowed
  // only when a read frees the slot at the same edge.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_mem.sv
// Single-clock FIFO for FloPoCo floating-point words (exception bits plus
// WIDTH-bit payload). Holds the storage array and the read-data path;
// pointer/count bookkeeping lives in fifo_ctrl.
module fifo_mem
  import fifo_mem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter bit REG_OUT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH+EXC_W-1:0] data_in,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH+EXC_W-1:0] data_out,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_BITS:0]     count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int W     = WIDTH + EXC_W;

  logic [W-1:0]         mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_wr;
  logic                 do_rd;

  fifo_ctrl #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .do_wr (do_wr),
    .do_rd (do_rd),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Storage write; words are kept bit-exact.
  // NOTE: the array has no reset; stale entries are unreachable once the
  // pointers and count are cleared, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data_in;
  end

  generate
    if (REG_OUT) begin : g_reg_out
      // Registered read port: loads the head entry only on an accepted read.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       data_out <= '0;
        else if (do_rd) data_out <= mem[rd_ptr];
      end
    end else begin : g_fwft
      // First-word fall-through: head entry shown directly, zero when empty.
      // NOTE: every path assigns data_out (default first), so no latch forms.
      always_comb begin
        data_out = '0;
        if (!empty) data_out = mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_mem.sv
// Directed self-checking bench for fifo_mem with REG_OUT=1, default geometry.
module tb_fifo_mem;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 2;
  localparam int W         = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     data_in;
  logic             wr_en;
  logic             rd_en;
  logic [W-1:0]     data_out;
  logic             full;
  logic             empty;
  logic [ADDR_BITS:0] count;

  int checks = 0;
  int errors = 0;

  fifo_mem #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .REG_OUT  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .data_out(data_out),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, settle 1 time unit.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [ADDR_BITS:0] c,
                           input logic f, input logic e);
    chk({tag, ".count"}, W'(count), W'(c));
    chk({tag, ".full"},  W'(full),  W'(f));
    chk({tag, ".empty"}, W'(empty), W'(e));
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    data_in = 34'h13DCCCCCD;

    // 1. Reset held for two edges with a write pending.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_state("reset", 3'd0, 1'b0, 1'b1);
    chk("reset.data_out", data_out, 34'h0);
    rst = 1'b1;

    // 2. Streaming write/read.
    step(1'b1, 1'b0, 34'h13DCCCCCD);
    chk("s2.count0", W'(count), W'(3'd1));
    step(1'b1, 1'b1, 34'h13F800000);
    chk("s2.out0", data_out, 34'h13DCCCCCD);
    chk("s2.count1", W'(count), W'(3'd1));
    step(1'b1, 1'b1, 34'h13F800001);
    chk("s2.out1", data_out, 34'h13F800000);
    chk("s2.count2", W'(count), W'(3'd1));
    step(1'b1, 1'b1, 34'h13F800003);
    chk("s2.out2", data_out, 34'h13F800001);
    chk("s2.count3", W'(count), W'(3'd1));
    step(1'b0, 1'b1, 34'h0);
    chk("s2.out3", data_out, 34'h13F800003);
    chk_state("s2.drained", 3'd0, 1'b0, 1'b1);

    // 3. Fill to full, drop a fifth write, drain in order.
    step(1'b1, 1'b0, 34'h040000001);
    step(1'b1, 1'b0, 34'h140000002);
    step(1'b1, 1'b0, 34'h240000003);
    step(1'b1, 1'b0, 34'h3FFFFFFFF);
    chk_state("s3.full", 3'd4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 34'h155555555);
    chk_state("s3.drop", 3'd4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 34'h0);
    chk("s3.rd0", data_out, 34'h040000001);
    step(1'b0, 1'b1, 34'h0);
    chk("s3.rd1", data_out, 34'h140000002);
    step(1'b0, 1'b1, 34'h0);
    chk("s3.rd2", data_out, 34'h240000003);
    step(1'b0, 1'b1, 34'h0);
    chk("s3.rd3", data_out, 34'h3FFFFFFFF);
    chk_state("s3.empty", 3'd0, 1'b0, 1'b1);

    // 4. Wrap-around: 3 in/3 out, then 4 in/4 out.
    step(1'b1, 1'b0, 34'h100000011);
    step(1'b1, 1'b0, 34'h100000022);
    step(1'b1, 1'b0, 34'h100000033);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.a0", data_out, 34'h100000011);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.a1", data_out, 34'h100000022);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.a2", data_out, 34'h100000033);
    step(1'b1, 1'b0, 34'h1A0000001);
    step(1'b1, 1'b0, 34'h2B0000002);
    step(1'b1, 1'b0, 34'h3C0000003);
    step(1'b1, 1'b0, 34'h0D0000004);
    chk_state("s4.full", 3'd4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.b0", data_out, 34'h1A0000001);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.b1", data_out, 34'h2B0000002);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.b2", data_out, 34'h3C0000003);
    step(1'b0, 1'b1, 34'h0);
    chk("s4.b3", data_out, 34'h0D0000004);
    chk_state("s4.empty", 3'd0, 1'b0, 1'b1);

    // 5a. Full with simultaneous read and write.
    step(1'b1, 1'b0, 34'h1000000A0);
    step(1'b1, 1'b0, 34'h1000000A1);
    step(1'b1, 1'b0, 34'h1000000A2);
    step(1'b1, 1'b0, 34'h1000000A3);
    step(1'b1, 1'b1, 34'h1000000A4);
    chk("s5a.out", data_out, 34'h1000000A0);
    chk_state("s5a.state", 3'd4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 34'h0);
    chk("s5a.rd1", data_out, 34'h1000000A1);
    step(1'b0, 1'b1, 34'h0);
    chk("s5a.rd2", data_out, 34'h1000000A2);
    step(1'b0, 1'b1, 34'h0);
    chk("s5a.rd3", data_out, 34'h1000000A3);
    step(1'b0, 1'b1, 34'h0);
    chk("s5a.rd4", data_out, 34'h1000000A4);
    chk_state("s5a.empty", 3'd0, 1'b0, 1'b1);

    // 5b. Empty with simultaneous read and write: write only.
    step(1'b1, 1'b1, 34'h2000000B0);
    chk("s5b.hold", data_out, 34'h1000000A4);
    chk_state("s5b.state", 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 34'h0);
    chk("s5b.rd", data_out, 34'h2000000B0);

    // 5c. Underflow: read while empty leaves everything alone.
    step(1'b0, 1'b1, 34'h0);
    chk("s5c.hold", data_out, 34'h2000000B0);
    chk_state("s5c.state", 3'd0, 1'b0, 1'b1);

    // 6. Asynchronous reset between edges with two entries stored.
    step(1'b1, 1'b0, 34'h3000000C0);
    step(1'b1, 1'b0, 34'h3000000C1);
    wr_en = 1'b0;
    chk("s6.pre", W'(count), W'(3'd2));
    #2;
    rst = 1'b0;
    #1;
    chk_state("s6.async", 3'd0, 1'b0, 1'b1);
    chk("s6.data_out", data_out, 34'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 34'h1DEADBEEF);
    step(1'b0, 1'b1, 34'h0);
    chk("s6.after", data_out, 34'h1DEADBEEF);
    chk_state("s6.after", 3'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
